// File: rtl/tx_pkg.sv
// Shared types and frame layout for the SPI transmit stage.
// Build option: define TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
package tx_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

`ifdef TX_CHECKSUM_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 3;
`endif

    localparam int IDX_W = $clog2(FRAME_BYTES);

    typedef logic [IDX_W-1:0] tx_idx_t;

    localparam tx_idx_t BYTE_STATUS = tx_idx_t'(0);
    localparam tx_idx_t BYTE_RES_HI = tx_idx_t'(1);
    localparam tx_idx_t BYTE_RES_LO = tx_idx_t'(2);
    localparam tx_idx_t BYTE_CSUM   = tx_idx_t'(3);
    localparam tx_idx_t LAST_IDX    = tx_idx_t'(FRAME_BYTES - 1);

    typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

    // Assemble the on-wire byte sequence for one ALU result.
    function automatic frame_t build_frame(input logic [7:0] status, input logic [15:0] data);
        frame_t f;
        f[BYTE_STATUS] = status;
        f[BYTE_RES_HI] = data[15:8];
        f[BYTE_RES_LO] = data[7:0];
`ifdef TX_CHECKSUM_EN
        f[BYTE_CSUM]   = status ^ data[15:8] ^ data[7:0];
`endif
        return f;
    endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Synchronises the asynchronous spi_clk into the clk domain and emits one
// registered single-cycle spi_rise per spi_clk rising edge.
module spi_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_clk,
    output logic spi_rise
);

    logic sync_out;
    logic prev;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign sync_out = spi_clk;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // NOTE: sequential state uses <= so every flop samples the pre-edge
        // value of its neighbour; blocking = here would collapse the chain.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= (sync_q << 1) | SYNC_STAGES'(spi_clk);
            end
        end

        assign sync_out = sync_q[SYNC_STAGES-1];
    end

    // Rise is registered so the pulse is glitch-free for the consuming FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= 1'b0;
            spi_rise <= 1'b0;
        end else begin
            prev     <= sync_out;
            spi_rise <= sync_out & ~prev;
        end
    end

endmodule

// File: rtl/tx.sv
// SPI transmit stage: accepts one ALU result and serialises it bytewise on miso.
// Build option: TX_CHECKSUM_EN adds a trailing XOR checksum byte (see tx_pkg).
module tx
    import tx_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_r,
    input  logic        res_valid,
    input  logic [7:0]  res_status,
    input  logic [15:0] res_data,
    output logic        tx_ready,
    output logic [7:0]  miso,
    output logic        tx_busy,
    output logic        frame_done
);

    tx_state_t state;
    tx_idx_t   idx;
    tx_idx_t   idx_next;
    frame_t    frame_buf;
    frame_t    frame_in;
    logic      spi_rise;

    spi_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_det (
        .clk      (clk),
        .rst      (rst),
        .spi_clk  (spi_clk),
        .spi_rise (spi_rise)
    );

    assign idx_next = idx + tx_idx_t'(1);
    assign frame_in = build_frame(res_status, res_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            // NOTE: the holding buffer is only a few bytes, so it is cleared
            // on reset like every other flop; large memories would not be.
            frame_buf  <= '0;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            miso       <= IDLE_BYTE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (res_valid && tx_ready) begin
                        state     <= SEND;
                        idx       <= '0;
                        frame_buf <= frame_in;
                        miso      <= frame_in[BYTE_STATUS];
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                SEND: begin
                    if (spi_rise && spi_r) begin
                        if (idx == LAST_IDX) begin
                            // A concurrent res_valid is seen only once tx_ready is back.
                            state      <= IDLE;
                            idx        <= '0;
                            miso       <= IDLE_BYTE;
                            tx_ready   <= 1'b1;
                            tx_busy    <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            idx  <= idx_next;
                            miso <= frame_buf[idx_next];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx.sv
// Self-checking bench for tx: directed scenarios plus random frames against a
// byte-queue model of the frame rules.
module tb_tx;

    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] IDLE_BYTE   = 8'h00;
    localparam int         PH          = SYNC_STAGES + 2;
`ifdef TX_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        spi_r;
    logic        res_valid;
    logic [7:0]  res_status;
    logic [15:0] res_data;
    logic        tx_ready;
    logic [7:0]  miso;
    logic        tx_busy;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    tx #(
        .SYNC_STAGES(SYNC_STAGES),
        .IDLE_BYTE  (IDLE_BYTE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .spi_r      (spi_r),
        .res_valid  (res_valid),
        .res_status (res_status),
        .res_data   (res_data),
        .tx_ready   (tx_ready),
        .miso       (miso),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; whenever frame_done shows, it must coincide with the idle outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) begin
            check("done_ready", 16'(tx_ready), 16'd1);
            check("done_busy", 16'(tx_busy), 16'd0);
            check("done_miso", 16'(miso), 16'(IDLE_BYTE));
        end
    endtask

    task automatic model_frame(input logic [7:0] status, input logic [15:0] data);
        logic [7:0] hi, lo;
        hi = data[15:8];
        lo = data[7:0];
        exp_q.push_back(status);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        if (CSUM) exp_q.push_back(status ^ hi ^ lo);
    endtask

    task automatic pulse(input logic r);
        spi_r   = r;
        spi_clk = 1'b1;
        repeat (PH) tick();
        spi_clk = 1'b0;
        repeat (PH) tick();
        spi_r   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] status, input logic [15:0] data);
        int w;
        w = 0;
        while (tx_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check("ready_before_accept", 16'(tx_ready), 16'd1);
        res_valid  = 1'b1;
        res_status = status;
        res_data   = data;
        tick();
        res_valid  = 1'b0;
        res_status = 8'($urandom);
        res_data   = 16'($urandom);
        model_frame(status, data);
        check("accept_busy", 16'(tx_busy), 16'd1);
        check("accept_ready", 16'(tx_ready), 16'd0);
        check("accept_byte0", 16'(miso), 16'(exp_q[0]));
    endtask

    // Master reads n bytes, sampling miso just before each spi_clk rise.
    task automatic read_frame(input int n, input bit gate);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            if (gate && $urandom_range(0, 2) == 0) begin
                pulse(1'b0);
                check("gated_hold", 16'(miso), 16'(exp_q[0]));
            end
            b = exp_q.pop_front();
            check("master_sample", 16'(miso), 16'(b));
            pulse(1'b1);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 16'(tx_ready), 16'd1);
        check({tag, "_busy"}, 16'(tx_busy), 16'd0);
        check({tag, "_miso"}, 16'(miso), 16'(IDLE_BYTE));
    endtask

    initial begin
        int d0;
        int w;
        logic [7:0]  st;
        logic [15:0] dt;

        rst        = 1'b1;
        spi_clk    = 1'b0;
        spi_r      = 1'b0;
        res_valid  = 1'b0;
        res_status = 8'h00;
        res_data   = 16'h0000;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_idle("reset");
        check("reset_done", 16'(frame_done), 16'd0);

        // Rises while idle are ignored.
        d0 = done_cnt;
        repeat (3) pulse(1'b1);
        check_idle("idle_pulses");
        check("idle_no_done", 16'(done_cnt - d0), 16'd0);

        // Basic frame with an exact byte-advance latency check on byte 0.
        d0 = done_cnt;
        send_frame(8'hA5, 16'h1234);
        spi_r   = 1'b1;
        spi_clk = 1'b1;
        repeat (PH - 1) tick();
        check("lat_hold", 16'(miso), 16'h00A5);
        tick();
        check("lat_adv", 16'(miso), 16'h0012);
        spi_clk = 1'b0;
        repeat (PH) tick();
        spi_r = 1'b0;
        void'(exp_q.pop_front());
        check("basic_byte1", 16'(miso), 16'h0012);
        read_frame(1, 1'b0);
        check("basic_byte2", 16'(miso), 16'h0034);
        if (CSUM) begin
            read_frame(1, 1'b0);
            check("basic_csum", 16'(miso), 16'h0083);
        end
        read_frame(exp_q.size(), 1'b0);
        check("basic_done_once", 16'(done_cnt - d0), 16'd1);
        check_idle("basic_end");

        // Backpressure: BEEF held valid during SEND waits for the frame to end.
        d0 = done_cnt;
        send_frame(8'h3C, 16'h55AA);
        read_frame(1, 1'b0);
        res_valid  = 1'b1;
        res_status = 8'hC3;
        res_data   = 16'hBEEF;
        tick();
        check("bp_not_ready", 16'(tx_ready), 16'd0);
        check("bp_hold_byte", 16'(miso), 16'(exp_q[0]));
        read_frame(exp_q.size(), 1'b0);
        check("bp_done_once", 16'(done_cnt - d0), 16'd1);
        check("bp_accepted", 16'(tx_busy), 16'd1);
        res_valid = 1'b0;
        model_frame(8'hC3, 16'hBEEF);
        read_frame(exp_q.size(), 1'b1);
        check("bp_done_two", 16'(done_cnt - d0), 16'd2);
        check_idle("bp_end");

        // Last-byte rise and res_valid in the same cycle.
        send_frame(8'($urandom), 16'($urandom));
        read_frame(exp_q.size() - 1, 1'b0);
        st = 8'($urandom);
        dt = 16'($urandom);
        res_valid  = 1'b1;
        res_status = st;
        res_data   = dt;
        check("sim_last_byte", 16'(miso), 16'(exp_q[0]));
        spi_r   = 1'b1;
        spi_clk = 1'b1;
        w = 0;
        while (frame_done !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("sim_done_seen", 16'(frame_done), 16'd1);
        exp_q.delete();
        model_frame(st, dt);
        tick();
        res_valid = 1'b0;
        check("sim_accept_busy", 16'(tx_busy), 16'd1);
        check("sim_accept_ready", 16'(tx_ready), 16'd0);
        check("sim_accept_byte0", 16'(miso), 16'(exp_q[0]));
        repeat (PH) tick();
        spi_clk = 1'b0;
        repeat (PH) tick();
        spi_r = 1'b0;
        check("sim_still_byte0", 16'(miso), 16'(exp_q[0]));
        read_frame(exp_q.size(), 1'b0);
        check_idle("sim_end");

        // Reset mid-frame after byte 0 has been read.
        send_frame(8'($urandom), 16'($urandom));
        read_frame(1, 1'b0);
        check("rst_pre_byte1", 16'(miso), 16'(exp_q[0]));
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        check_idle("rst_mid");
        check("rst_mid_done", 16'(frame_done), 16'd0);
        rst = 1'b0;
        exp_q.delete();
        pulse(1'b1);
        check_idle("rst_after");
        check("rst_no_done", 16'(done_cnt - d0), 16'd0);

        // Random frames with randomly gated reads.
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            send_frame(8'($urandom), 16'($urandom));
            read_frame(exp_q.size(), 1'b1);
            check("rand_done_once", 16'(done_cnt - d0), 16'd1);
            check_idle("rand_end");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
